// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 128-bit ALU: a first-word-fall-through queue of
// {result, flags, opsel, mode}, plus sticky flags and a saturating stall counter.
module alu_result_fifo #(
  parameter int DWIDTH = 128,
  parameter int DEPTH  = 4,
  parameter int SCW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DWIDTH-1:0]          in_result,
  input  logic                       in_c,
  input  logic                       in_z,
  input  logic                       in_o,
  input  logic                       in_s,
  input  logic [2:0]                 in_opsel,
  input  logic                       in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DWIDTH-1:0]          out_result,
  output logic [3:0]                 out_flags,
  output logic [2:0]                 out_opsel,
  output logic                       out_mode,
  output logic [$clog2(DEPTH):0]     count,
  output logic [3:0]                 sticky_flags,
  input  logic                       sticky_clr,
  output logic [SCW-1:0]             stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = DWIDTH + 8;

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] head;
  logic [3:0]    flags_in;
  logic [3:0]    push_flags;
  logic          push;
  logic          pop;

  assign in_ready   = (count != CW'(DEPTH));
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign flags_in   = {in_c, in_z, in_o, in_s};
  assign push_flags = push ? flags_in : '0;

  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head[BW-1:8] : '0;
  assign out_flags  = out_valid ? head[7:4]    : '0;
  assign out_opsel  = out_valid ? head[3:1]    : '0;
  assign out_mode   = out_valid ? head[0]      : 1'b0;

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {in_result, flags_in, in_opsel, in_mode};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= push_flags;
    end else begin
      sticky_flags <= sticky_flags | push_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: queue scoreboard with independent
// occupancy/sticky/stall model, a vector table, and directed corner sequences.
module tb_alu_result_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_result = '0;
  logic         in_c = 1'b0, in_z = 1'b0, in_o = 1'b0, in_s = 1'b0;
  logic [2:0]   in_opsel = '0;
  logic         in_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_result;
  logic [3:0]   out_flags;
  logic [2:0]   out_opsel;
  logic         out_mode;
  logic [2:0]   count;
  logic [3:0]   sticky_flags;
  logic         sticky_clr = 1'b0;
  logic [15:0]  stall_cnt;

  alu_result_fifo #(.DWIDTH(128), .DEPTH(4), .SCW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_c(in_c), .in_z(in_z), .in_o(in_o), .in_s(in_s),
    .in_opsel(in_opsel), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .out_opsel(out_opsel), .out_mode(out_mode), .count(count),
    .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] r;
    logic [3:0]   f;
    logic [2:0]   op;
    logic         m;
  } entry_t;

  typedef struct {
    logic [127:0] r;
    logic [3:0]   f;
    logic [2:0]   op;
    logic         m;
    logic         clr;
    logic [3:0]   exp_sticky;
  } vec_t;

  entry_t q[$];
  int     tests  = 0;
  int     failed = 0;
  bit     model_ok = 1'b0;
  logic [3:0]  m_sticky;
  logic [15:0] m_stall;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard and reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    entry_t e;
    bit     m_push, m_pop;
    if (model_ok) begin
      chk("count", 136'(count), 136'(q.size()));
      chk("in_ready", 136'(in_ready), 136'(q.size() != 4));
      chk("out_valid", 136'(out_valid), 136'(q.size() != 0));
      chk("sticky", 136'(sticky_flags), 136'(m_sticky));
      chk("stall", 136'(stall_cnt), 136'(m_stall));
      if (q.size() != 0) chk("head", {out_result, out_flags, out_opsel, out_mode}, q[0]);
      else chk("idle_zero", {out_result, out_flags, out_opsel, out_mode}, '0);
    end
    if (rst) begin
      q.delete();
      m_sticky = '0;
      m_stall  = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_push = in_valid && (q.size() != 4);
      m_pop  = (q.size() != 0) && out_ready;
      if (in_valid && !m_push && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (sticky_clr) m_sticky = m_push ? {in_c, in_z, in_o, in_s} : 4'b0;
      else if (m_push) m_sticky = m_sticky | {in_c, in_z, in_o, in_s};
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        e = '{r: in_result, f: {in_c, in_z, in_o, in_s}, op: in_opsel, m: in_mode};
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] r, input logic [3:0] f,
                       input logic [2:0] op, input logic m);
    in_valid  = 1'b1;
    in_result = r;
    {in_c, in_z, in_o, in_s} = f;
    in_opsel  = op;
    in_mode   = m;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    sticky_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (count != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_bound", 136'(count), 136'(0));
  endtask

  vec_t vecs[6];
  logic [15:0] s0;
  bit done;

  initial begin
    vecs[0] = '{128'hA0, 4'b0001, 3'd1, 1'b0, 1'b0, 4'b0001};
    vecs[1] = '{128'hA1, 4'b0010, 3'd2, 1'b1, 1'b0, 4'b0011};
    vecs[2] = '{128'hA2, 4'b0000, 3'd3, 1'b0, 1'b1, 4'b0000};
    vecs[3] = '{128'hA3, 4'b1000, 3'd4, 1'b1, 1'b0, 4'b1000};
    vecs[4] = '{128'hA4, 4'b0100, 3'd5, 1'b0, 1'b1, 4'b0100};
    vecs[5] = '{{64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FFFF_0000}, 4'b1011, 3'd7, 1'b1, 1'b0, 4'b1111};

    do_reset();
    chk("rst_count", 136'(count), 136'(0));
    chk("rst_in_ready", 136'(in_ready), 136'(1));
    chk("rst_out_valid", 136'(out_valid), 136'(0));

    // Single pass-through
    out_ready = 1'b1;
    drive(128'h1, 4'b1000, 3'b010, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("pt_valid", 136'(out_valid), 136'(1));
    chk("pt_bundle", {out_result, out_flags, out_opsel, out_mode}, {128'h1, 4'b1000, 3'b010, 1'b0});
    chk("pt_count1", 136'(count), 136'(1));
    tick();
    chk("pt_count0", 136'(count), 136'(0));
    chk("pt_sticky", 136'(sticky_flags), 136'(4'b1000));

    // Vector table: one push per cycle with sticky_clr variations
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].op, vecs[i].m);
      sticky_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_sticky", i), 136'(sticky_flags), 136'(vecs[i].exp_sticky));
      chk($sformatf("vec%0d_out", i), {out_result, out_flags, out_opsel, out_mode},
          {vecs[i].r, vecs[i].f, vecs[i].op, vecs[i].m});
    end
    sticky_clr = 1'b0;
    drain();

    // Fill and backpressure
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(128'(10 + i), 4'b0001, 3'd0, 1'b0);
      tick();
    end
    drive(128'd14, 4'b0010, 3'd1, 1'b1);
    chk("fill_count", 136'(count), 136'(4));
    chk("fill_in_ready", 136'(in_ready), 136'(0));
    chk("fill_stall0", 136'(stall_cnt), 136'(0));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("fill_stall%0d", i), 136'(stall_cnt), 136'(i));
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    chk("fill_14_accepted", 136'(done), 136'(1));
    drain();

    // Wrap-around streaming
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(128'(i), 4'(i), 3'(i), 1'(i));
      tick();
      chk("stream_count_le1", 136'(count <= 3'd1), 136'(1));
    end
    drain();

    // Sticky clear collision
    do_reset();
    out_ready = 1'b1;
    drive(128'h55, 4'b1111, 3'd6, 1'b0);
    tick();
    chk("clr_accum", 136'(sticky_flags), 136'(4'b1111));
    drive(128'h66, 4'b0100, 3'd6, 1'b1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    in_valid   = 1'b0;
    chk("clr_collide", 136'(sticky_flags), 136'(4'b0100));
    drain();

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(128'(30 + i), 4'b1111, 3'd2, 1'b1);
      tick();
    end
    chk("mid_count3", 136'(count), 136'(3));
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_count", 136'(count), 136'(0));
    chk("mid_out_valid", 136'(out_valid), 136'(0));
    chk("mid_out_result", 136'(out_result), 136'(0));
    chk("mid_stall", 136'(stall_cnt), 136'(0));
    chk("mid_sticky", 136'(sticky_flags), 136'(0));

    // Full with simultaneous ready: pop only, stall still counts
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(128'(40 + i), 4'b0000, 3'd3, 1'b0);
      tick();
    end
    chk("full_count4", 136'(count), 136'(4));
    s0 = stall_cnt;
    drive(128'd99, 4'b0001, 3'd3, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("full_pop_count", 136'(count), 136'(3));
    chk("full_stall_inc", 136'(stall_cnt), 136'(s0 + 16'd1));
    chk("full_head_next", 136'(out_result), 136'(41));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
